mips_load_store_unit: RTL and testbench
=======================================

Name: mips_load_store_unit

Overview:
- Sits between the datapath (ALU address result, rt store data) and the word-addressed data memory (combinational read, posedge write).
- Adds MIPS byte and halfword accesses: LB, LBU, LH, LHU, LW, SB, SH, SW.
- Sub-word stores use a read-modify-write sequence; loads are extracted and sign- or zero-extended.
- Uses a valid/ready request handshake and a one-cycle done pulse so the control unit can stall.

Parameters:
- MEM_WORDS, 256, number of 32-bit words in the data memory.
- IDX_W, 8, word-index width, equal to log2(MEM_WORDS).

Ports:
- clk  in  1  system clock; all state updates on the posedge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  access request from the datapath.
- req_ready  out  1  high only in IDLE; a request is accepted on a posedge with req_valid & req_ready.
- req_op  in  3  access type; encoding is in the package.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the low byte or halfword is used for SB/SH.
- done  out  1  one-cycle pulse when the access completes.
- err  out  1  valid with done; 1 = misaligned or out-of-range access, no memory access performed.
- load_data  out  32  extended load result; valid with done, held until the next load completes.
- address  out  32  to memory: {zeros, word index}.
- write_data  out  32  to memory.
- memWrite  out  1  to memory.
- memRead  out  1  to memory.
- read_data  in  32  from memory, combinational.

Behaviour:
- Reset: state IDLE; done=0, err=0, load_data=0, memRead=0, memWrite=0, address=0, write_data=0; req_ready=1 after reset is released.
- States and transitions:
  - IDLE: on acceptance, latch op, addr and wdata, then branch. If checks fail, go ERR. Otherwise loads go LOAD, SW goes STORE, SB/SH go RMW_RD.
  - LOAD: memRead=1, address=idx. On the posedge, latch the extracted and extended lane into load_data. Go RESP.
  - RMW_RD: memRead=1. Latch read_data into the merge buffer. Go STORE.
  - STORE: memWrite=1, memRead=0. write_data is wdata for SW, or the merge buffer with the target lane replaced for SB/SH. Go RESP.
  - RESP: done=1, err=0. Go IDLE.
  - ERR: done=1, err=1. memRead and memWrite stay 0; load_data is unchanged. Go IDLE.
- Latency from the acceptance edge to the cycle in which done is high:
  - 2 cycles for LW, LH, LHU, LB, LBU and SW.
  - 3 cycles for SB and SH.
  - 1 cycle for errors.
- Checks:
  - Word index is req_addr[IDX_W+1:2].
  - Out of range: req_addr[31:IDX_W+2] != 0.
  - Misaligned: LW/SW with addr[1:0] != 0, or halfword ops with addr[0] != 0.
- Lane selection is big-endian:
  - Byte offset 0 is bits 31:24 and offset 3 is bits 7:0.
  - Halfword offset 0 is bits 31:16 and offset 2 is bits 15:0.
  - LB and LH sign-extend; LBU and LHU zero-extend.
- Outside LOAD, RMW_RD and STORE: memRead=0, memWrite=0, address=0, write_data=0.
- req_valid while not in IDLE is ignored (req_ready=0); no queueing.
- Reset mid-operation: memWrite and memRead are gated by !reset. A STORE cycle coincident with reset must not write memory. The FSM returns to IDLE and no done is issued.
- Undefined req_op codes are treated as errors (ERR path).

Decomposition:
- Package mips_lsu_pkg holds:
  - Op encodings: LB=000, LH=001, LW=011, LBU=100, LHU=101, SB=110, SH=111, SW=010.
  - The FSM state enum.
  - Helper constants OP_IS_STORE and OP_IS_UNSIGNED bit positions.
- Sub-module mips_byte_lane: purely combinational extract/extend (word, offset, op -> load value) and merge (word, wdata, offset, op -> merged word). The FSM lives in the top module.

Test Plan:
- Memory word 4 = 0x8899AABB; LB at addr 0x11 -> done 2 cycles after acceptance, load_data=0xFFFFFF99. LBU at the same address -> 0x00000099.
- Word 4 = 0x8899AABB; LH at 0x12 -> 0xFFFFAABB. LHU at 0x10 -> 0x00008899. memWrite stays 0 throughout.
- Word 2 = 0x11223344; SB at 0x0A with wdata 0xDEADBEEF -> one memRead cycle, then one memWrite cycle writing 0x1122EF44; done 3 cycles after acceptance.
- SW at 0x400 (out of range) and LW at 0x06 (misaligned) -> done with err=1 one cycle after acceptance; memRead and memWrite stay 0; load_data unchanged.
- Assert reset while in STORE for SH to word 3 -> memWrite=0 on that edge, word 3 unchanged, next state IDLE, req_ready=1, no done pulse.
- req_valid held high for back-to-back LW 0x00 then LW 0x04 -> second request accepted only after RESP; req_ready low for 2 cycles between acceptances; both load_data values correct.

Source files
------------

// File: rtl/mips_load_store_unit_pkg.sv
// Shared definitions for the MIPS load/store unit: op encodings, FSM states
// and small op-decoding helpers.
package mips_lsu_pkg;

    // Access type carried on req_op.
    typedef enum logic [2:0] {
        OP_LB  = 3'b000,
        OP_LH  = 3'b001,
        OP_SW  = 3'b010,
        OP_LW  = 3'b011,
        OP_LBU = 3'b100,
        OP_LHU = 3'b101,
        OP_SB  = 3'b110,
        OP_SH  = 3'b111
    } op_e;

    // Controller states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RMW_RD = 3'd2,
        ST_STORE  = 3'd3,
        ST_RESP   = 3'd4,
        ST_ERR    = 3'd5
    } state_e;

    // Bit 1 marks a store when bit 2 is set or bit 0 is clear (SW/SB/SH);
    // among loads, bit 2 selects zero-extension (LBU/LHU).
    localparam int OP_IS_STORE    = 1;
    localparam int OP_IS_UNSIGNED = 2;

    function automatic logic op_is_store(input op_e op);
        return op[OP_IS_STORE] & (op[2] | ~op[0]);
    endfunction

    // Every 3-bit code is currently assigned; the default arm keeps any
    // future unassigned code on the error path.
    function automatic logic op_is_defined(input op_e op);
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
            OP_SB, OP_SH, OP_SW: return 1'b1;
            default:             return 1'b0;
        endcase
    endfunction

    // Word ops need addr[1:0]==0, halfword ops need addr[0]==0.
    function automatic logic op_misaligned(input op_e op, input logic [1:0] off);
        case (op)
            OP_LW, OP_SW:          return off != 2'b00;
            OP_LH, OP_LHU, OP_SH:  return off[0];
            default:               return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mips_load_store_unit_if.sv
// Bundle of the datapath request/response signals and the data-memory port.
// Handshake: a request transfers on a posedge where req_valid && req_ready;
// req_ready is high only while the unit is idle, and completion is a single
// cycle of done with err/load_data valid alongside it.
interface mips_lsu_if;

    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        done;
    logic        err;
    logic [31:0] load_data;
    logic [31:0] address;
    logic [31:0] write_data;
    logic        memWrite;
    logic        memRead;
    logic [31:0] read_data;

    // System side: datapath requests and the memory's read return.
    modport master (
        output req_valid, req_op, req_addr, req_wdata, read_data,
        input  req_ready, done, err, load_data, address, write_data,
               memWrite, memRead
    );

    // Load/store unit side.
    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, read_data,
        output req_ready, done, err, load_data, address, write_data,
               memWrite, memRead
    );

endinterface

// File: rtl/mips_load_store_unit_byte_lane.sv
// Big-endian byte/halfword lane logic: extracts and extends a load value
// from a memory word, and merges store data into a word for sub-word stores.
import mips_lsu_pkg::*;

module mips_byte_lane (
    input  logic [31:0] i_word,
    input  logic [15:0] i_wdata,
    input  logic [1:0]  i_offset,
    input  op_e         i_op,
    output logic [31:0] o_load,
    output logic [31:0] o_merged
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane select, extension and merge; offset 0 is the most significant lane.
    always_comb begin
        w_byte   = 8'h00;
        w_half   = i_offset[1] ? i_word[15:0] : i_word[31:16];
        o_load   = i_word;
        o_merged = i_word;
        case (i_offset)
            2'd0:    w_byte = i_word[31:24];
            2'd1:    w_byte = i_word[23:16];
            2'd2:    w_byte = i_word[15:8];
            default: w_byte = i_word[7:0];
        endcase
        case (i_op)
            OP_LB, OP_LBU: o_load = i_op[OP_IS_UNSIGNED] ? {24'h0, w_byte}
                                                         : {{24{w_byte[7]}}, w_byte};
            OP_LH, OP_LHU: o_load = i_op[OP_IS_UNSIGNED] ? {16'h0, w_half}
                                                         : {{16{w_half[15]}}, w_half};
            default:       o_load = i_word;
        endcase
        case (i_op)
            OP_SB: begin
                case (i_offset)
                    2'd0:    o_merged[31:24] = i_wdata[7:0];
                    2'd1:    o_merged[23:16] = i_wdata[7:0];
                    2'd2:    o_merged[15:8]  = i_wdata[7:0];
                    default: o_merged[7:0]   = i_wdata[7:0];
                endcase
            end
            OP_SH: begin
                if (i_offset[1]) o_merged[15:0]  = i_wdata;
                else             o_merged[31:16] = i_wdata;
            end
            default: o_merged = i_word;
        endcase
    end

endmodule

// File: rtl/mips_load_store_unit.sv
// MIPS load/store unit: accepts one access at a time, checks alignment and
// range, performs word loads/stores directly and sub-word stores as a
// read-modify-write, and reports completion with a one-cycle done pulse.
import mips_lsu_pkg::*;

module mips_load_store_unit #(
    parameter int MEM_WORDS = 256,
    parameter int IDX_W     = 8
) (
    input  logic         i_clk,
    input  logic         i_reset,
    mips_lsu_if.slave    bus,
    output state_e       o_state
);

    state_e      r_state;
    op_e         r_op;
    logic [1:0]  r_offset;
    logic [31:0] r_wdata;
    logic [31:0] r_address;
    logic [31:0] r_write_data;   // doubles as the merge buffer for SB/SH
    logic [31:0] r_load_data;
    logic        r_mem_read;
    logic        r_mem_write;
    logic        r_done;
    logic        r_err;

    op_e         w_op;
    logic [31:0] w_idx_ext;
    logic        w_oor;
    logic        w_bad;
    logic [31:0] w_load;
    logic [31:0] w_merged;

    assign w_op      = op_e'(bus.req_op);
    assign w_idx_ext = {{(32 - IDX_W){1'b0}}, bus.req_addr[IDX_W+1:2]};
    assign w_oor     = (|bus.req_addr[31:IDX_W+2]) || (w_idx_ext >= 32'(MEM_WORDS));
    assign w_bad     = w_oor || op_misaligned(w_op, bus.req_addr[1:0]) || !op_is_defined(w_op);

    mips_byte_lane u_lane (
        .i_word   (bus.read_data),
        .i_wdata  (r_wdata[15:0]),
        .i_offset (r_offset),
        .i_op     (r_op),
        .o_load   (w_load),
        .o_merged (w_merged)
    );

    // Access sequencer; all outputs are registered alongside the state.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_op         <= OP_LB;
            r_offset     <= 2'b00;
            r_wdata      <= 32'h0;
            r_address    <= 32'h0;
            r_write_data <= 32'h0;
            r_load_data  <= 32'h0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        r_op     <= w_op;
                        r_offset <= bus.req_addr[1:0];
                        r_wdata  <= bus.req_wdata;
                        if (w_bad) begin
                            r_state <= ST_ERR;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end else if (!op_is_store(w_op)) begin
                            r_state    <= ST_LOAD;
                            r_mem_read <= 1'b1;
                            r_address  <= w_idx_ext;
                        end else if (w_op == OP_SW) begin
                            r_state      <= ST_STORE;
                            r_mem_write  <= 1'b1;
                            r_address    <= w_idx_ext;
                            r_write_data <= bus.req_wdata;
                        end else begin
                            r_state    <= ST_RMW_RD;
                            r_mem_read <= 1'b1;
                            r_address  <= w_idx_ext;
                        end
                    end
                end
                ST_LOAD: begin
                    r_load_data <= w_load;
                    r_mem_read  <= 1'b0;
                    r_address   <= 32'h0;
                    r_done      <= 1'b1;
                    r_state     <= ST_RESP;
                end
                ST_RMW_RD: begin
                    r_write_data <= w_merged;
                    r_mem_read   <= 1'b0;
                    r_mem_write  <= 1'b1;
                    r_state      <= ST_STORE;
                end
                ST_STORE: begin
                    r_mem_write  <= 1'b0;
                    r_address    <= 32'h0;
                    r_write_data <= 32'h0;
                    r_done       <= 1'b1;
                    r_state      <= ST_RESP;
                end
                ST_RESP: r_state <= ST_IDLE;
                ST_ERR:  r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Memory strobes are masked by reset so an in-flight store never lands.
    assign bus.memRead    = r_mem_read  & ~i_reset;
    assign bus.memWrite   = r_mem_write & ~i_reset;
    assign bus.address    = r_address;
    assign bus.write_data = r_write_data;
    assign bus.load_data  = r_load_data;
    assign bus.done       = r_done;
    assign bus.err        = r_err;
    assign bus.req_ready  = (r_state == ST_IDLE);
    assign o_state        = r_state;

endmodule

// File: tb/tb_mips_load_store_unit.sv
import mips_lsu_pkg::*;

module tb_mips_load_store_unit;

    logic        clk;
    logic        reset;
    state_e      state;
    mips_lsu_if  bus();

    logic [31:0] mem [256];
    logic [31:0] shd [256];
    logic [32:0] exp_q [$];
    int          n_checks;
    int          n_fail;
    int          rd_cnt;
    int          wr_cnt;
    logic [31:0] last_ld;

    mips_load_store_unit #(.MEM_WORDS(256), .IDX_W(8)) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus),
        .o_state (state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: combinational read, posedge write
    assign bus.read_data = mem[bus.address[7:0]];
    always @(posedge clk) begin
        if (bus.memWrite) mem[bus.address[7:0]] <= bus.write_data;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: pop on every done pulse, count memory strobes
    always @(negedge clk) begin
        if (bus.memRead)  rd_cnt++;
        if (bus.memWrite) wr_cnt++;
        if (bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_done", 1, 0);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                check_eq("resp_err", {63'h0, bus.err}, {63'h0, e[32]});
                check_eq("resp_load_data", {32'h0, bus.load_data}, {32'h0, e[31:0]});
            end
        end
    end

    function automatic logic [31:0] model_load(input logic [2:0] op, input logic [31:0] w, input logic [1:0] off);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * (3 - int'(off)))) & 32'hFF;
        h = (w >> (16 * (1 - int'(off[1])))) & 32'hFFFF;
        case (op)
            3'b000:  return b[7]  ? (b | 32'hFFFFFF00) : b;
            3'b100:  return b;
            3'b001:  return h[15] ? (h | 32'hFFFF0000) : h;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    // Driver: issue one request, wait for done, check latency and strobes
    task automatic do_req(input string tag, input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] wdata, input int exp_lat, input int exp_rd,
                          input int exp_wr, input logic exp_err, input logic [31:0] exp_ld);
        int lat;
        bit got;
        @(negedge clk);
        check_eq({tag, "_ready"}, {63'h0, bus.req_ready}, 64'h1);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        exp_q.push_back({exp_err, exp_ld});
        last_ld = exp_ld;
        rd_cnt = 0;
        wr_cnt = 0;
        lat = 0;
        got = 0;
        while (!got && lat < 10) begin
            @(negedge clk);
            lat++;
            if (bus.done === 1'b1) got = 1;
        end
        if (!got) check_eq({tag, "_timeout"}, 0, 1);
        else      check_eq({tag, "_latency"}, lat, exp_lat);
        check_eq({tag, "_rd_cycles"}, rd_cnt, exp_rd);
        check_eq({tag, "_wr_cycles"}, wr_cnt, exp_wr);
    endtask

    initial begin
        int n;
        bit got;
        n_checks = 0;
        n_fail   = 0;
        rd_cnt   = 0;
        wr_cnt   = 0;
        last_ld  = 32'h0;
        bus.req_valid = 1'b0;
        bus.req_op    = 3'b000;
        bus.req_addr  = 32'h0;
        bus.req_wdata = 32'h0;
        for (int i = 0; i < 256; i++) begin
            mem[i] = $urandom;
            shd[i] = mem[i];
        end
        mem[0] = 32'h01234567;
        mem[1] = 32'h89ABCDEF;
        mem[2] = 32'h11223344;
        mem[3] = 32'hCAFEF00D;
        mem[4] = 32'h8899AABB;

        // Reset
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_eq("rst_done",       {63'h0, bus.done}, 0);
        check_eq("rst_err",        {63'h0, bus.err}, 0);
        check_eq("rst_load_data",  {32'h0, bus.load_data}, 0);
        check_eq("rst_memRead",    {63'h0, bus.memRead}, 0);
        check_eq("rst_memWrite",   {63'h0, bus.memWrite}, 0);
        check_eq("rst_address",    {32'h0, bus.address}, 0);
        check_eq("rst_write_data", {32'h0, bus.write_data}, 0);
        check_eq("rst_ready",      {63'h0, bus.req_ready}, 1);
        check_eq("rst_state",      {61'h0, state}, {61'h0, ST_IDLE});

        // Sub-word loads from word 4 = 0x8899AABB
        do_req("lb_11",  3'b000, 32'h11, 32'h0, 2, 1, 0, 1'b0, 32'hFFFFFF99);
        do_req("lbu_11", 3'b100, 32'h11, 32'h0, 2, 1, 0, 1'b0, 32'h00000099);
        do_req("lh_12",  3'b001, 32'h12, 32'h0, 2, 1, 0, 1'b0, 32'hFFFFAABB);
        do_req("lhu_10", 3'b101, 32'h10, 32'h0, 2, 1, 0, 1'b0, 32'h00008899);

        // Sub-word stores (read-modify-write)
        do_req("sb_0a", 3'b110, 32'h0A, 32'hDEADBEEF, 3, 1, 1, 1'b0, last_ld);
        check_eq("sb_0a_mem", {32'h0, mem[2]}, {32'h0, 32'h1122EF44});
        do_req("sh_06", 3'b111, 32'h06, 32'h00001234, 3, 1, 1, 1'b0, last_ld);
        check_eq("sh_06_mem", {32'h0, mem[1]}, {32'h0, 32'h89AB1234});
        do_req("sw_14", 3'b010, 32'h14, 32'hA5A5_5A5A, 2, 0, 1, 1'b0, last_ld);
        check_eq("sw_14_mem", {32'h0, mem[5]}, {32'h0, 32'hA5A55A5A});

        // Error paths
        do_req("sw_oor",   3'b010, 32'h400, 32'h12345678, 1, 0, 0, 1'b1, last_ld);
        do_req("lw_mis",   3'b011, 32'h06,  32'h0,        1, 0, 0, 1'b1, last_ld);
        do_req("lh_mis",   3'b001, 32'h01,  32'h0,        1, 0, 0, 1'b1, last_ld);
        do_req("lbu_high", 3'b100, 32'h8000_0000, 32'h0,  1, 0, 0, 1'b1, last_ld);
        do_req("lw_08",    3'b011, 32'h08,  32'h0,        2, 1, 0, 1'b0, 32'h1122EF44);

        // Reset while in STORE of an SH to word 3
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = 3'b111;
        bus.req_addr  = 32'h0C;
        bus.req_wdata = 32'h00005555;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        check_eq("rstmid_rmw_rd", {63'h0, bus.memRead}, 1);
        @(negedge clk);
        check_eq("rstmid_in_store", {61'h0, state}, {61'h0, ST_STORE});
        reset = 1'b1;
        #1;
        check_eq("rstmid_memWrite", {63'h0, bus.memWrite}, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        last_ld = 32'h0;
        @(negedge clk);
        check_eq("rstmid_state", {61'h0, state}, {61'h0, ST_IDLE});
        check_eq("rstmid_ready", {63'h0, bus.req_ready}, 1);
        check_eq("rstmid_done",  {63'h0, bus.done}, 0);
        check_eq("rstmid_mem3",  {32'h0, mem[3]}, {32'h0, 32'hCAFEF00D});
        repeat (2) @(negedge clk);

        // Back-to-back LW with req_valid held high
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = 3'b011;
        bus.req_addr  = 32'h00;
        @(posedge clk);
        #1;
        exp_q.push_back({1'b0, 32'h01234567});
        bus.req_addr = 32'h04;
        n = 0;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (bus.req_ready === 1'b1) got = 1;
            else n++;
        end
        check_eq("b2b_ready_low", n, 2);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        exp_q.push_back({1'b0, 32'h89AB1234});
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) got = 1;
        end
        check_eq("b2b_second_done", {63'h0, got}, 1);
        last_ld = 32'h89AB1234;

        // Random sub-word and word loads from untouched words
        for (int i = 0; i < 12; i++) begin
            int          idx;
            int          sel;
            logic [2:0]  op;
            logic [1:0]  off;
            idx = $urandom_range(16, 255);
            sel = $urandom_range(0, 4);
            case (sel)
                0: begin op = 3'b000; off = 2'($urandom_range(0, 3)); end
                1: begin op = 3'b100; off = 2'($urandom_range(0, 3)); end
                2: begin op = 3'b001; off = 2'($urandom_range(0, 1) * 2); end
                3: begin op = 3'b101; off = 2'($urandom_range(0, 1) * 2); end
                default: begin op = 3'b011; off = 2'b00; end
            endcase
            do_req("rnd_load", op, {22'h0, 8'(idx), off}, 32'h0, 2, 1, 0, 1'b0,
                   model_load(op, shd[idx], off));
        end

        repeat (3) @(negedge clk);
        check_eq("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
